counter_ctrl: RTL
=================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter data width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter MAX_CYCLES, default 300, RUN cycle limit (used only when timeout is compiled in).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command FIFO can accept.
REQ-008 cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-009 cmd_data  input  WIDTH  load value or count target.
REQ-010 cnt_load  output  1  load strobe to downstream counter.
REQ-011 cnt_din  output  WIDTH  load value / compare target to counter.
REQ-012 cnt_enable, cnt_inc, cnt_dec  output  1 each  counter step controls.
REQ-013 cnt_count  input  WIDTH  registered count from counter.
REQ-014 rsp_valid  output  1  command completed.
REQ-015 rsp_ready  input  1  response consumed.
REQ-016 rsp_count  output  WIDTH  cnt_count sampled at completion.
REQ-017 rsp_err  output  1  command aborted by timeout.
REQ-018 busy  output  1  state != IDLE or FIFO non-empty.

Function
REQ-019 Command SHALL be pushed into FIFO on a cycle where cmd_valid && cmd_ready; cmd_ready = FIFO not full; no push-to-pop bypass.
REQ-020 FSM states SHALL be IDLE, LOAD, RUN, RESP.
REQ-021 IDLE: if FIFO non-empty, pop head into op/target registers; LOAD or CLEAR -> LOAD; UP or DOWN -> RUN; else stay IDLE.
REQ-022 LOAD: cnt_load=1 for exactly one cycle, cnt_din = cmd_data (0 for CLEAR); next state RESP.
REQ-023 RUN: cnt_din = target; cnt_enable = cnt_inc(UP) or cnt_dec(DOWN) = (cnt_count != target), combinational; when cnt_count == target, no step is issued and next state is RESP.
REQ-024 UP/DOWN with target equal to current count SHALL issue zero steps and enter RESP after one RUN cycle.
REQ-025 Counting SHALL wrap modulo 2^WIDTH (UP from 250 to 3 takes 9 steps); cnt_inc and cnt_dec never both 1.
REQ-026 RESP: rsp_valid=1 with rsp_count/rsp_err stable until rsp_ready sampled high; then IDLE.
REQ-027 rsp_count SHALL be cnt_count captured on the cycle of entry into RESP (LOAD: value after load takes effect).
REQ-028 Latency: command accepted at cycle T, empty FIFO, IDLE -> cnt_load high at T+2, rsp_valid high at T+3.
REQ-029 Outside LOAD/RUN, cnt_load, cnt_enable, cnt_inc, cnt_dec SHALL be 0; cnt_din holds last value.
REQ-030 Push and pop in same cycle SHALL keep FIFO level unchanged; FIFO order SHALL be preserved.

Reset
REQ-031 reset_n low SHALL immediately force: state IDLE, FIFO empty, cmd_ready=1, all cnt_* outputs 0, rsp_valid=0, rsp_count=0, rsp_err=0, busy=0.
REQ-032 Reset mid-RUN or mid-RESP SHALL discard the current command and all queued commands, with no response issued.

Configuration
REQ-033 Macro CNT_CTRL_TIMEOUT_EN defined: RUN cycle counter cleared on entry; when RUN cycles reach MAX_CYCLES without match, stop stepping, enter RESP with rsp_err=1.
REQ-034 Macro undefined: no timeout logic; rsp_err tied 0; RUN waits indefinitely.

Verification
REQ-035 Reset, push LOAD 0x5A at T -> cnt_load=1, cnt_din=0x5A at T+2; rsp_valid at T+3, rsp_count=0x5A, rsp_err=0.
REQ-036 Count at 10, UP target 15 -> exactly 5 cnt_inc cycles, rsp_count=15; DOWN target 15 from 15 -> zero steps, rsp_count=15.
REQ-037 Count at 250, UP target 3 -> 9 steps with wrap, rsp_count=3.
REQ-038 Hold rsp_ready=0, push 5 commands -> cmd_ready low after 4 queued (plus 1 in flight as configured), responses in push order once rsp_ready=1.
REQ-039 With CNT_CTRL_TIMEOUT_EN, MAX_CYCLES=20, counter model stuck -> rsp_valid after 20 RUN cycles, rsp_err=1.
REQ-040 Assert reset_n low mid-RUN with 2 queued -> outputs zero immediately, busy=0, no response after release.

Source files
------------

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Brief    : Queued command sequencer for an external up/down counter.
//            Optional RUN timeout is compiled in with CNT_CTRL_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module counter_ctrl #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CYCLES = 300
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_din,
    output logic             cnt_enable,
    output logic             cnt_inc,
    output logic             cnt_dec,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_count,
    output logic             rsp_err,
    output logic             busy
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FIFO_W = WIDTH + 2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   din_q;
    logic               load_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [WIDTH-1:0]   rsp_count_q;
    logic               resp_first_q;

    logic [FIFO_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic [1:0]         head_op;
    logic [WIDTH-1:0]   head_data;

    logic               match;
    logic               timeout;
    logic               step;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign {head_op, head_data} = fifo_mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef CNT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(MAX_CYCLES + 1);

    logic [TW-1:0] run_cyc_q;

    // The MAX_CYCLES-th RUN cycle issues no step and hands off to RESP.
    assign timeout = (state_q == S_RUN) && (run_cyc_q == TW'(MAX_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cyc_q <= '0;
        end else if (state_q != S_RUN) begin
            run_cyc_q <= '0;
        end else begin
            run_cyc_q <= run_cyc_q + TW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign match      = (cnt_count == din_q);
    assign step       = (state_q == S_RUN) && !match && !timeout;
    assign cnt_inc    = step && (op_q == OP_UP);
    assign cnt_dec    = step && (op_q == OP_DOWN);
    assign cnt_enable = cnt_inc || cnt_dec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LOAD;
            din_q        <= '0;
            load_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_count_q  <= '0;
            resp_first_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        op_q  <= head_op;
                        din_q <= (head_op == OP_CLEAR) ? '0 : head_data;
                        if (head_op == OP_LOAD || head_op == OP_CLEAR) begin
                            state_q <= S_LOAD;
                            load_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_LOAD: begin
                    load_q       <= 1'b0;
                    state_q      <= S_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_err_q    <= 1'b0;
                    resp_first_q <= 1'b1;
                end
                S_RUN: begin
                    if (match || timeout) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= !match;
                        resp_first_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    resp_first_q <= 1'b0;
                    if (resp_first_q) rsp_count_q <= cnt_count;
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The counter only reflects a load one cycle after the strobe, so the first
    // RESP cycle forwards the live count and later cycles replay the captured one.
    assign rsp_count = resp_first_q ? cnt_count : rsp_count_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign cnt_load  = load_q;
    assign cnt_din   = din_q;
    assign cmd_ready = !fifo_full;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule
`default_nettype wire
